// File: rtl/carpim_kontrol.sv
// Sequential shift-and-add 8x8 -> 16-bit unsigned multiplier controller.
// One shared _16bitadder is stepped once per clock over eight iterations.

module _16bitadder (
  input  logic [15:0] in1,
  input  logic [15:0] in2,
  input  logic        carryin,
  input  logic        topla,
  output logic [15:0] sum,
  output logic        carryout
);

  logic [15:0] w_b;
  logic        w_c;

  // topla gates the second operand: sum = in1 + (topla ? in2 : 0) + carryin
  assign w_b = topla ? in2 : 16'h0000;

  // NOTE: the carry is a local variable in always_comb, written before it is read on every path, so no latch is inferred.
  always_comb begin
    w_c = carryin;
    sum = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      sum[i] = in1[i] ^ w_b[i] ^ w_c;
      w_c    = (in1[i] & w_b[i]) | (w_c & (in1[i] ^ w_b[i]));
    end
    carryout = w_c;
  end

endmodule

module carpim_kontrol (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  in1,
  input  logic [7:0]  in2,
  output logic [15:0] out,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [15:0] r_acc;
  logic [15:0] r_mcand;
  logic [7:0]  r_mplier;
  logic [2:0]  r_cnt;
  logic [15:0] r_out;
  logic        r_busy;
  logic        r_done;

  logic [15:0] w_sum;
  logic        w_carryout;

  _16bitadder u_adder (
    .in1      (r_acc),
    .in2      (r_mcand),
    .carryin  (1'b0),
    .topla    (r_mplier[0]),
    .sum      (w_sum),
    .carryout (w_carryout)
  );

  // NOTE: every state register uses non-blocking assignment and is cleared by the async reset; there is no memory array here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_acc    <= 16'h0000;
      r_mcand  <= 16'h0000;
      r_mplier <= 8'h00;
      r_cnt    <= 3'd0;
      r_out    <= 16'h0000;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_mcand  <= {8'h00, in1};
            r_mplier <= in2;
            r_acc    <= 16'h0000;
            r_cnt    <= 3'd0;
            r_busy   <= 1'b1;
            r_state  <= CALC;
          end
        end
        CALC: begin
          r_acc    <= w_sum;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 3'd1;
          if (r_cnt == 3'd7) begin
            r_out   <= w_sum;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Largest product 255*255 fits in 16 bits, so the adder never carries out.
  a_no_carryout : assert property (@(posedge clk) disable iff (!rst_n) !w_carryout);

  assign out  = r_out;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_carpim_kontrol.sv
// Self-checking bench for carpim_kontrol: directed cases plus randomized
// operands checked against an arithmetic product and cycle-count timing model.

module tb_carpim_kontrol;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  in1;
  logic [7:0]  in2;
  logic [15:0] out;
  logic        busy;
  logic        done;

  int          total;
  int          bad;
  logic [15:0] exp_out;
  logic        co_seen;

  carpim_kontrol dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .in1   (in1),
    .in2   (in2),
    .out   (out),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (dut.w_carryout === 1'b1) co_seen = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Called at a falling edge. mode 0: quiet, 1: inject start with 1x1 during
  // CALC/DONE, 2: random input churn while busy. Returns at the falling edge after E9.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int mode);
    logic [15:0] prod;
    prod  = 16'(a) * 16'(b);
    in1   = a;
    in2   = b;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("e0_busy", busy, 1);
    check("e0_done", done, 0);
    for (int k = 1; k <= 8; k++) begin
      if (mode == 1) begin
        in1 = 8'd1; in2 = 8'd1; start = 1'b1;
      end else if (mode == 2) begin
        in1 = 8'($urandom); in2 = 8'($urandom); start = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      @(negedge clk);
      if (k < 8) begin
        check("calc_busy", busy, 1);
        check("calc_done", done, 0);
        check("calc_out_hold", out, exp_out);
      end
    end
    exp_out = prod;
    check("e8_busy", busy, 0);
    check("e8_done", done, 1);
    check("e8_out", out, exp_out);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("e9_busy", busy, 0);
    check("e9_done", done, 0);
    check("e9_out", out, exp_out);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    total   = 0;
    bad     = 0;
    exp_out = 16'h0000;
    co_seen = 1'b0;
    rst_n   = 1'b0;
    start   = 1'b0;
    in1     = 8'h00;
    in2     = 8'h00;
    #3;
    check("rst_out", out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(8'd13, 8'd11, 0);
    check("prod_13x11", out, 143);
    repeat (3) @(negedge clk);
    check("hold_143", out, 143);

    run_op(8'd255, 8'd255, 0);
    check("prod_255x255", out, 16'hFE01);
    check("carryout_never", co_seen, 0);

    run_op(8'd0, 8'd200, 0);
    check("zero_a", out, 0);
    run_op(8'd200, 8'd0, 0);
    check("zero_b", out, 0);

    run_op(8'd20, 8'd30, 1);
    check("ignore_start_600", out, 600);
    repeat (12) begin
      @(negedge clk);
      check("no_extra_done", done, 0);
    end

    // start held high: product 7x9, then in1 drops to 3 mid-calculation
    in1 = 8'd7; in2 = 8'd9; start = 1'b1;
    for (int k = 0; k < 30; k++) begin
      if (k == 3) in1 = 8'd3;
      @(posedge clk);
      @(negedge clk);
      if (k == 8) exp_out = 16'd63;
      if (k == 18) exp_out = 16'd27;
      check("held_busy", busy, ((k % 10) <= 7) ? 1 : 0);
      check("held_done", done, ((k % 10) == 8) ? 1 : 0);
      check("held_out", out, exp_out);
    end
    start = 1'b0;
    check("held_last_27", out, 27);

    // Asynchronous reset during the fourth CALC cycle
    in1 = 8'd100; in2 = 8'd50; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_out = 16'h0000;
    check("midrst_out", out, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      check("post_rst_done", done, 0);
      check("post_rst_busy", busy, 0);
    end
    run_op(8'd6, 8'd7, 0);
    check("prod_6x7", out, 42);

    for (int n = 0; n < 20; n++) begin
      logic [7:0] a;
      logic [7:0] b;
      a = 8'($urandom);
      b = 8'($urandom);
      if (n == 0) a = 8'd0;
      if (n == 1) b = 8'd255;
      run_op(a, b, 2);
      check("rand_prod", out, 16'(a) * 16'(b));
    end
    check("carryout_never_end", co_seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/carpim_kontrol.md
# carpim_kontrol

Sequential shift-and-add controller that computes an unsigned 8×8→16-bit product by driving one shared `_16bitadder` instance over eight iterations. It accepts operands on a start pulse and steps the adder once per clock, using the multiplier LSB as the adder's `topla` gate. It raises `done` for one cycle when the product is valid. It sits between the operand source and any consumer of the 16-bit product, and is the only master of its adder instance.

## Interface
- No parameters; width is fixed at 8-bit operands and a 16-bit product, matching `_16bitadder`.

- `clk`  input  1  rising-edge clock
- `rst_n`  input  1  asynchronous, active-low reset
- `start`  input  1  request; sampled only in IDLE
- `in1`  input  8  multiplicand (unsigned)
- `in2`  input  8  multiplier (unsigned)
- `out`  output  16  product register; updated only on completion
- `busy`  output  1  high while in CALC
- `done`  output  1  one-cycle completion strobe

## Operation
- Internal registers:
  - `acc[15:0]` accumulator
  - `mcand[15:0]` shifted multiplicand
  - `mplier[7:0]` multiplier shift register
  - `cnt[2:0]` iteration counter
  - `state` ∈ {IDLE, CALC, DONE}
- Adder hookup: `in1=acc`, `in2=mcand`, `carryin=0`, `topla=mplier[0]`, giving `sum = acc + (mplier[0] ? mcand : 0)`.
- The adder's `carryout` is unused. The product is at most 255×255 = 65025, so `carryout` never asserts.
- IDLE:
  - If `start`=1 at a clock edge: `mcand<={8'b0,in1}`, `mplier<=in2`, `acc<=0`, `cnt<=0`, go to CALC.
  - Otherwise stay in IDLE.
- CALC (one adder step per edge):
  - `acc<=sum`, `mcand<=mcand<<1`, `mplier<=mplier>>1`, `cnt<=cnt+1`.
  - When `cnt==7` at the edge: also `out<=sum` and go to DONE.
- DONE:
  - Lasts exactly one cycle, then returns to IDLE unconditionally.
- `start` is ignored in CALC and DONE. It is not queued, and the operands on `in1`/`in2` are not re-sampled.
- `in1`/`in2` may change freely after the accepting edge; only the latched copies are used.
- `out` holds the last completed product until the next completion or reset. It is never updated mid-calculation.
- Zero operands still take the full 8 iterations; there is no early termination.

## Timing
- Reset (`rst_n`=0, asynchronous, takes effect immediately and regardless of clock):
  - `state`=IDLE.
  - `out`=16'h0000, `busy`=0, `done`=0.
  - `acc`, `mcand`, `mplier`, `cnt` all 0.
- Release of reset is synchronous in effect: the first `start` is sampled at the first rising edge with `rst_n`=1.
- Cycle timing, with E0 the edge that samples `start`=1 in IDLE:
  - E0 → `busy`=1.
  - E1–E8 are the eight CALC steps.
  - After E8: `busy`=0, `done`=1, `out` holds the product.
  - After E9: `done`=0, state IDLE.
  - E10 is the earliest edge at which a new `start` is accepted.
- Latency from the `start`-sampling edge to `done` high is 8 cycles. Throughput is one product per 10 cycles with `start` held high.
- `busy` and `done` are never high together. Both are registered (state-decoded), with no combinational path from `start`.
- Reset mid-CALC or in DONE: the operation is aborted, all outputs return to their reset values, and no `done` pulse is produced.

## Test plan
- `in1`=13, `in2`=11, `start` pulsed for 1 cycle → `busy` high for 8 cycles, then `done`=1 for exactly one cycle with `out`=143 (16'h008F); `out` stays 143 afterwards.
- `in1`=255, `in2`=255 → `out`=16'hFE01; adder `carryout` never observed at 1.
- `in1`=0, `in2`=200, then `in1`=200, `in2`=0 → each `done` arrives at E0+8 with `out`=0.
- `start` held high continuously with `in1`=7, `in2`=9 → `done` pulses every 10 cycles, `out`=63. Changing `in1` to 3 while `busy`=1 does not affect the current result; the next result is 27.
- `in1`=100, `in2`=50, assert `rst_n`=0 asynchronously at the 4th CALC cycle → `out`/`busy`/`done` immediately 0 and no `done` pulse follows. After release, `in1`=6, `in2`=7 → `out`=42.
- Second `start` with `in1`=1, `in2`=1 issued during CALC and again during DONE of a 20×30 operation → both ignored; `out`=600 and only one `done` pulse.
